// File: rtl/dmem_pkg.sv
// Shared constants, requester IDs and address checking for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DMEM_DATA_W   = 32;
  localparam int unsigned DMEM_ADDR_W   = 32;
  localparam int unsigned DMEM_DEPTH    = 8192;
  localparam int unsigned DMEM_MAX_WAIT = 4;
  localparam int unsigned MEM_ADDR_W    = 32;
  localparam int unsigned CNT_W         = 4;

  // Owner of an in-flight read; routes the returning data.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CPU  = 2'd1,
    REQ_DMA  = 2'd2
  } req_id_e;

  // True when a word address falls inside the memory.
  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/dmem_starve_counter.sv
// Counts consecutive cycles the DMA port loses arbitration and flags a forced grant.
module dmem_starve_counter
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DMEM_MAX_WAIT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_dma_req,
  input  logic i_dma_win,
  output logic o_force_dma_c
);

  logic [CNT_W-1:0] r_cnt;

  // Saturating loss counter, cleared on a DMA win or an idle DMA port.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (!i_dma_req || i_dma_win) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(MAX_WAIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_force_dma_c = (r_cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: CPU priority with DMA starvation guard.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DEPTH    = DMEM_DEPTH,
  parameter int unsigned MAX_WAIT = DMEM_MAX_WAIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_W-1:0]     dma_addr,
  input  logic [DATA_W-1:0]     dma_wdata,
  output logic                  dma_ack,
  output logic                  dma_err,
  output logic                  dma_rvalid,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  logic              w_force_dma;
  logic              w_dma_win;
  logic              w_cpu_win;
  logic              w_any_win;
  logic              w_sel_we;
  logic              w_sel_ok;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  req_id_e           r_ret_id;

  dmem_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_dma_req     (dma_req),
    .i_dma_win     (w_dma_win),
    .o_force_dma_c (w_force_dma)
  );

  assign w_dma_win = dma_req && (!cpu_req || w_force_dma);
  assign w_cpu_win = cpu_req && !w_dma_win;
  assign w_any_win = w_dma_win || w_cpu_win;

  // Select the winning requester's fields and range-check its address.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_ok    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_dma_win) begin
      w_sel_we    = dma_we;
      w_sel_ok    = addr_in_range(64'(dma_addr), 64'(DEPTH));
      w_sel_addr  = dma_addr;
      w_sel_wdata = dma_wdata;
    end else if (w_cpu_win) begin
      w_sel_we    = cpu_we;
      w_sel_ok    = addr_in_range(64'(cpu_addr), 64'(DEPTH));
      w_sel_addr  = cpu_addr;
      w_sel_wdata = cpu_wdata;
    end
  end

  // Issue registers: acks, error flags, memory strobes and the read owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      dma_ack   <= 1'b0;
      dma_err   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r_ret_id  <= REQ_NONE;
    end else begin
      cpu_ack   <= w_cpu_win;
      cpu_err   <= w_cpu_win && !w_sel_ok;
      dma_ack   <= w_dma_win;
      dma_err   <= w_dma_win && !w_sel_ok;
      mem_read  <= w_any_win && w_sel_ok && !w_sel_we;
      mem_write <= w_any_win && w_sel_ok && w_sel_we;
      mem_addr  <= MEM_ADDR_W'(w_sel_addr);
      mem_wdata <= w_sel_wdata;
      if (w_any_win && w_sel_ok && !w_sel_we) begin
        r_ret_id <= w_dma_win ? REQ_DMA : REQ_CPU;
      end else begin
        r_ret_id <= REQ_NONE;
      end
    end
  end

  // Return path: capture memory data one cycle after a read issue and pulse the owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      cpu_rvalid <= (r_ret_id == REQ_CPU);
      dma_rvalid <= (r_ret_id == REQ_DMA);
      if (r_ret_id == REQ_CPU) begin
        cpu_rdata <= mem_rdata;
      end
      if (r_ret_id == REQ_DMA) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

  localparam int ID_CPU = 1;
  localparam int ID_DMA = 2;

  typedef struct {
    int          id;
    bit          err;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack, cpu_err, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_ack, dma_err, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:8191];

  int checks = 0;
  int failures = 0;

  grant_t      q_grant[$];
  logic [31:0] q_cpu_rd[$];
  logic [31:0] q_dma_rd[$];
  bit          p_cpu_rd = 1'b0;
  bit          p_dma_rd = 1'b0;

  dmem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_err    (cpu_err),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ack    (dma_ack),
    .dma_err    (dma_err),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory model: write at posedge, read data after negedge of the issue cycle.
  always @(posedge clock) begin
    if (mem_write) mem[mem_addr[12:0]] <= mem_wdata;
  end
  always @(negedge clock) begin
    if (mem_read) mem_rdata <= mem[mem_addr[12:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void exp_grant(input int id, input bit err, input bit we,
                                    input logic [31:0] addr, input logic [31:0] wd);
    grant_t g;
    g.id = id; g.err = err; g.rd = !err && !we; g.wr = !err && we;
    g.addr = addr; g.wdata = wd;
    q_grant.push_back(g);
  endfunction

  // Monitor: pop and compare whenever the DUT presents an ack or a read return.
  always @(posedge clock) begin
    grant_t g;
    bit exp_cv, exp_dv;
    #1;
    if (mem_read && mem_write) chk("rd_wr_exclusive", 32'(1), 32'(0));
    if (cpu_ack && dma_ack) chk("dual_ack", 32'(1), 32'(0));
    if (cpu_ack || dma_ack) begin
      if (q_grant.size() == 0) begin
        chk("unexpected_grant", 32'(cpu_ack ? ID_CPU : ID_DMA), 32'(0));
      end else begin
        g = q_grant.pop_front();
        chk("grant_id", 32'(cpu_ack ? ID_CPU : ID_DMA), 32'(g.id));
        chk("grant_err", 32'(cpu_ack ? cpu_err : dma_err), 32'(g.err));
        chk("grant_mem_read", 32'(mem_read), 32'(g.rd));
        chk("grant_mem_write", 32'(mem_write), 32'(g.wr));
        if (!g.err) chk("grant_mem_addr", mem_addr, g.addr);
        if (g.wr) chk("grant_mem_wdata", mem_wdata, g.wdata);
      end
    end else if (cpu_err || dma_err || mem_read || mem_write) begin
      chk("idle_issue_outputs", {28'd0, cpu_err, dma_err, mem_read, mem_write}, 32'(0));
    end
    exp_cv = p_cpu_rd && !reset;
    exp_dv = p_dma_rd && !reset;
    if (cpu_rvalid || p_cpu_rd) chk("cpu_rvalid_lag", 32'(cpu_rvalid), 32'(exp_cv));
    if (dma_rvalid || p_dma_rd) chk("dma_rvalid_lag", 32'(dma_rvalid), 32'(exp_dv));
    if (cpu_rvalid) begin
      if (q_cpu_rd.size() == 0) chk("unexpected_cpu_rvalid", cpu_rdata, 32'hFFFF_FFFF);
      else chk("cpu_rdata", cpu_rdata, q_cpu_rd.pop_front());
    end
    if (dma_rvalid) begin
      if (q_dma_rd.size() == 0) chk("unexpected_dma_rvalid", dma_rdata, 32'hFFFF_FFFF);
      else chk("dma_rdata", dma_rdata, q_dma_rd.pop_front());
    end
    p_cpu_rd = cpu_ack && mem_read;
    p_dma_rd = dma_ack && mem_read;
  end

  task automatic cpu_do(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bit got = 1'b0;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clock); #1;
      if (cpu_ack) got = 1'b1;
    end
    cpu_req = 1'b0;
    if (!got) chk("cpu_ack_timeout", 32'(got), 32'(1));
  endtask

  task automatic dma_do(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bit got = 1'b0;
    @(negedge clock);
    dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clock); #1;
      if (dma_ack) got = 1'b1;
    end
    dma_req = 1'b0;
    if (!got) chk("dma_ack_timeout", 32'(got), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_acks"}, {28'd0, cpu_ack, cpu_err, dma_ack, dma_err}, 32'(0));
    chk({tag, "_rvalids"}, {30'd0, cpu_rvalid, dma_rvalid}, 32'(0));
    chk({tag, "_mem_strobes"}, {30'd0, mem_read, mem_write}, 32'(0));
    chk({tag, "_mem_addr"}, mem_addr, 32'(0));
    chk({tag, "_mem_wdata"}, mem_wdata, 32'(0));
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'(0));
    chk({tag, "_dma_rdata"}, dma_rdata, 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'hA000_0000 + 32'(i);

    // Reset state
    repeat (3) @(posedge clock);
    #1 check_all_zero("reset");
    @(negedge clock) reset = 1'b0;
    repeat (2) @(posedge clock);

    // CPU write then read-back of address 5
    exp_grant(ID_CPU, 1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    exp_grant(ID_CPU, 1'b0, 1'b0, 32'd5, 32'd0);
    q_cpu_rd.push_back(32'hDEAD_BEEF);
    cpu_do(1'b1, 32'd5, 32'hDEAD_BEEF);
    cpu_do(1'b0, 32'd5, 32'd0);
    repeat (3) @(posedge clock);

    // Contention: CPU x4 then forced DMA, repeating
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        exp_grant(ID_CPU, 1'b0, 1'b0, 32'(100 + 4 * k + j), 32'd0);
        q_cpu_rd.push_back(32'hA000_0000 + 32'(100 + 4 * k + j));
      end
      exp_grant(ID_DMA, 1'b0, 1'b0, 32'(200 + k), 32'd0);
      q_dma_rd.push_back(32'hA000_0000 + 32'(200 + k));
    end
    fork
      begin
        for (int i = 0; i < 12; i++) cpu_do(1'b0, 32'(100 + i), 32'd0);
      end
      begin
        for (int i = 0; i < 3; i++) dma_do(1'b0, 32'(200 + i), 32'd0);
      end
    join
    repeat (3) @(posedge clock);

    // DMA alone, back-to-back reads of 0,1,2
    for (int i = 0; i < 3; i++) begin
      exp_grant(ID_DMA, 1'b0, 1'b0, 32'(i), 32'd0);
      q_dma_rd.push_back(32'hA000_0000 + 32'(i));
    end
    for (int i = 0; i < 3; i++) dma_do(1'b0, 32'(i), 32'd0);
    repeat (3) @(posedge clock);

    // Range boundary: 8192 errors, 8191 is the last legal word
    exp_grant(ID_CPU, 1'b1, 1'b0, 32'd8192, 32'd0);
    cpu_do(1'b0, 32'd8192, 32'd0);
    exp_grant(ID_CPU, 1'b0, 1'b0, 32'd8191, 32'd0);
    q_cpu_rd.push_back(32'hA000_1FFF);
    cpu_do(1'b0, 32'd8191, 32'd0);
    repeat (3) @(posedge clock);

    // Reset right after a read ack discards the return
    exp_grant(ID_CPU, 1'b0, 1'b0, 32'd9, 32'd0);
    cpu_do(1'b0, 32'd9, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1 check_all_zero("mid_reset");
    @(negedge clock) reset = 1'b0;
    exp_grant(ID_CPU, 1'b0, 1'b0, 32'd10, 32'd0);
    q_cpu_rd.push_back(32'hA000_000A);
    cpu_do(1'b0, 32'd10, 32'd0);
    repeat (3) @(posedge clock);

    // Simultaneous CPU write and DMA read of address 7
    exp_grant(ID_CPU, 1'b0, 1'b1, 32'd7, 32'h11);
    exp_grant(ID_DMA, 1'b0, 1'b0, 32'd7, 32'd0);
    q_dma_rd.push_back(32'h11);
    fork
      cpu_do(1'b1, 32'd7, 32'h11);
      dma_do(1'b0, 32'd7, 32'd0);
    join
    repeat (5) @(posedge clock);

    chk("grant_queue_drained", 32'(q_grant.size()), 32'(0));
    chk("cpu_rd_queue_drained", 32'(q_cpu_rd.size()), 32'(0));
    chk("dma_rd_queue_drained", 32'(q_dma_rd.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory (8192 x 32-bit words, word-addressed) between the CPU load/store port and a DMA/loader port.
- Registers one winning request per cycle onto the memory-side signals.
- Returns read data to the originating requester.
- Flags out-of-range addresses instead of accessing memory.
- CPU has priority. A starvation counter forces a DMA grant after MAX_WAIT lost cycles.

Parameters:
- DATA_W, 32, data width of requesters and memory.
- ADDR_W, 32, requester address width (word address).
- DEPTH, 8192, number of memory words. Legal addresses are 0..DEPTH-1.
- MAX_WAIT, 4, consecutive cycles DMA may lose before it is forced to win (range 1..15).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU request valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ack  out  1  one-cycle pulse: request accepted.
- cpu_err  out  1  qualifies cpu_ack: address out of range, no access made.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  DATA_W  read return, held until the next cpu_rvalid.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_err, dma_rvalid, dma_rdata: same as the cpu_* ports, for the DMA port.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data (valid after the negedge of the issue cycle).

Behaviour:
- Reset: every output is 0, the wait counter is 0, any pending read return is discarded, and last-granted = none. Memory contents are untouched. Reset takes priority over every event in the same cycle.
- Handshake:
  - A requester holds req and its fields stable until it samples ack=1.
  - In the ack cycle it may drop req, or present a new request with req held high; at the next posedge that is arbitrated as new.
- Arbitration, evaluated at each posedge:
  - Winner = DMA if dma_req && (!cpu_req || wait_cnt == MAX_WAIT).
  - Otherwise winner = CPU if cpu_req.
  - Otherwise no winner.
- Issue: if there is a winner at posedge N, then during cycle N:
  - the winner's ack = 1;
  - mem_addr and mem_wdata are driven from the winner's fields;
  - mem_write = we and mem_read = !we.
  - All other issue-path outputs are 0. mem_read and mem_write are never both 1.
- Out of range (addr >= DEPTH): ack=1 with err=1; mem_read = mem_write = 0 that cycle; no rvalid follows.
- Read latency: a read issued at posedge N has mem_rdata captured at posedge N+1. rvalid is raised to the originator during cycle N+1. Throughput is one access per cycle; back-to-back reads give rvalid on consecutive cycles.
- Write: performed by memory at posedge N+1; no return pulse.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each posedge where dma_req=1 and DMA does not win.
  - Clears on a DMA win or when dma_req=0.
- Simultaneous events:
  - Both ports requesting with wait_cnt < MAX_WAIT: CPU wins.
  - A return pulse to one port and an ack to the other in the same cycle is legal.
- Read-after-write to the same address in consecutive grants returns the new data, since the memory writes on posedge before the negedge read.

Decomposition:
- Shared package dmem_pkg:
  - DATA_W and DEPTH constants;
  - requester-ID enum {REQ_NONE, REQ_CPU, REQ_DMA}, used for the return-routing register;
  - address range check function.
- One natural sub-module: dmem_starve_counter (saturating wait counter with clear, exposes the force_dma flag).
- The pick, issue registers and return routing stay in dmem_arbiter.

Test Plan:
- CPU write addr 5 = 0xDEADBEEF, then CPU read addr 5 -> cpu_ack on both issue cycles; cpu_rvalid one cycle after the read ack with cpu_rdata = 0xDEADBEEF; dma_* outputs stay 0.
- Both ports request reads continuously, MAX_WAIT=4 -> pattern CPU,CPU,CPU,CPU,DMA repeating; dma_ack every 5th cycle; wait counter clears after each DMA ack.
- DMA alone issues reads of addresses 0,1,2 back-to-back -> dma_ack for 3 cycles; dma_rvalid for 3 consecutive cycles, each lagging its ack by one cycle, with the matching data.
- CPU read addr 8192 -> cpu_ack=1 and cpu_err=1 in the same cycle; mem_read=0; no cpu_rvalid.
- reset asserted the cycle after a CPU read ack -> no cpu_rvalid; all outputs 0; first request after reset is served normally.
- CPU write addr 7 = 0x11 and DMA read addr 7 requested together -> CPU write issues first; DMA read issues next cycle and returns 0x11.
